// File: rtl/mem_access_stage.sv
// mem_access_stage
//   MEM-stage consumer of the EX/MEM pipeline register. Non-memory results
//   are registered straight through to the WB side. Loads and stores run a
//   single-outstanding request/ack transaction on the data bus while
//   stallreq holds the front of the pipe.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   mem_*             EX/MEM register outputs (dest, write enables, ALU
//                     result, HI/LO, memory op, address, store data)
//   stallreq          combinational; high = upstream must hold mem_* stable
//   bus_*             registered request side of the data bus; bus_rdata and
//                     bus_ack come back from memory (ack is a 1-cycle pulse)
//   wb_*              registered MEM/WB outputs, bubble when no result
//   err_misalign      1-cycle pulse for a misaligned LW/SW (no bus access)
//   err_timeout       1-cycle pulse when a transaction is abandoned
//   dbg_state         current FSM state (0 = IDLE, 1 = BUSY)
//
// Handshake: bus_req rises at the edge after a memory op is accepted and is
// held, with bus_we/addr/sel/wdata stable, until the cycle in which bus_ack
// is sampled high (or the wait is abandoned); it falls at that edge. Only
// one request is ever outstanding and an ack seen while idle is ignored.
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic        mem_whilo,
  input  logic [31:0] mem_hi,
  input  logic [31:0] mem_lo,
  input  logic [2:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_sdata,
  output logic        stallreq,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        wb_whilo,
  output logic [31:0] wb_hi,
  output logic [31:0] wb_lo,
  output logic        err_misalign,
  output logic        err_timeout,
  output logic        dbg_state
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;

  logic            is_lw, is_sw, is_lb, is_lbu, is_sb;
  logic            aligned, mem_req, misalign, timeout_hit;
  logic [1:0]      lane;
  logic [3:0]      req_sel;
  logic [31:0]     req_wdata;
  logic [31:0]     rd_shift;
  logic [31:0]     load_result;

  assign is_lw    = (mem_op == 3'd1);
  assign is_sw    = (mem_op == 3'd2);
  assign is_lb    = (mem_op == 3'd3);
  assign is_lbu   = (mem_op == 3'd4);
  assign is_sb    = (mem_op == 3'd5);
  assign lane     = mem_addr[1:0];
  assign aligned  = (lane == 2'b00);
  assign mem_req  = is_lb | is_lbu | is_sb | ((is_lw | is_sw) & aligned);
  assign misalign = (is_lw | is_sw) & ~aligned;

  // Final BUSY cycle before the wait is abandoned.
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  assign req_sel   = (is_lw | is_sw) ? 4'hF : (4'b0001 << lane);
  assign req_wdata = is_sb ? {4{mem_sdata[7:0]}} : mem_sdata;

  // Selected byte lane moved down to bits [7:0].
  assign rd_shift = bus_rdata >> {lane, 3'b000};

  always_comb begin
    load_result = mem_wdata;
    case (mem_op)
      3'd1:    load_result = bus_rdata;
      3'd3:    load_result = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'd4:    load_result = {24'd0, rd_shift[7:0]};
      default: load_result = mem_wdata;
    endcase
  end

  // The abandon cycle releases the stall so the dropped instruction leaves
  // the stage instead of being re-issued.
  always_comb begin
    stallreq = 1'b0;
    if (state == IDLE) stallreq = mem_req;
    else               stallreq = ~bus_ack & ~timeout_hit;
  end

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_sel      <= '0;
      bus_wdata    <= '0;
      wb_wd        <= '0;
      wb_wreg      <= 1'b0;
      wb_wdata     <= '0;
      wb_whilo     <= 1'b0;
      wb_hi        <= '0;
      wb_lo        <= '0;
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
      // Bubble unless a branch below emits a result.
      wb_wd    <= '0;
      wb_wreg  <= 1'b0;
      wb_wdata <= '0;
      wb_whilo <= 1'b0;
      wb_hi    <= '0;
      wb_lo    <= '0;
      case (state)
        IDLE: begin
          if (mem_req) begin
            state     <= BUSY;
            cnt       <= '0;
            bus_req   <= 1'b1;
            bus_we    <= is_sw | is_sb;
            bus_addr  <= {mem_addr[31:2], 2'b00};
            bus_sel   <= req_sel;
            bus_wdata <= req_wdata;
          end else begin
            wb_wd        <= mem_wd;
            wb_wreg      <= misalign ? (is_sw & mem_wreg) : mem_wreg;
            wb_wdata     <= mem_wdata;
            wb_whilo     <= mem_whilo;
            wb_hi        <= mem_hi;
            wb_lo        <= mem_lo;
            err_misalign <= misalign;
          end
        end
        BUSY: begin
          if (bus_ack) begin
            state    <= IDLE;
            bus_req  <= 1'b0;
            wb_wd    <= mem_wd;
            wb_wreg  <= mem_wreg;
            wb_wdata <= load_result;
            wb_whilo <= mem_whilo;
            wb_hi    <= mem_hi;
            wb_lo    <= mem_lo;
          end else if (timeout_hit) begin
            state       <= IDLE;
            bus_req     <= 1'b0;
            err_timeout <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  logic [4:0]  mem_wd = '0;
  logic        mem_wreg = 1'b0;
  logic [31:0] mem_wdata = '0;
  logic        mem_whilo = 1'b0;
  logic [31:0] mem_hi = '0;
  logic [31:0] mem_lo = '0;
  logic [2:0]  mem_op = '0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_sdata = '0;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;

  logic        stallreq, bus_req, bus_we, wb_wreg, wb_whilo, err_misalign, err_timeout, dbg_state;
  logic [31:0] bus_addr, bus_wdata, wb_wdata, wb_hi, wb_lo;
  logic [3:0]  bus_sel;
  logic [4:0]  wb_wd;

  logic        stallreq_t, bus_req_t, bus_we_t, wb_wreg_t, wb_whilo_t, err_misalign_t, err_timeout_t, dbg_state_t;
  logic [31:0] bus_addr_t, bus_wdata_t, wb_wdata_t, wb_hi_t, wb_lo_t;
  logic [3:0]  bus_sel_t;
  logic [4:0]  wb_wd_t;

  mem_access_stage #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_op(mem_op),
    .mem_addr(mem_addr), .mem_sdata(mem_sdata), .stallreq(stallreq), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .wb_wd(wb_wd), .wb_wreg(wb_wreg),
    .wb_wdata(wb_wdata), .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
    .err_misalign(err_misalign), .err_timeout(err_timeout), .dbg_state(dbg_state)
  );

  mem_access_stage #(.TIMEOUT(4)) dut_to (
    .clk(clk), .rst(rst), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_op(mem_op),
    .mem_addr(mem_addr), .mem_sdata(mem_sdata), .stallreq(stallreq_t), .bus_req(bus_req_t),
    .bus_we(bus_we_t), .bus_addr(bus_addr_t), .bus_sel(bus_sel_t), .bus_wdata(bus_wdata_t),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .wb_wd(wb_wd_t), .wb_wreg(wb_wreg_t),
    .wb_wdata(wb_wdata_t), .wb_whilo(wb_whilo_t), .wb_hi(wb_hi_t), .wb_lo(wb_lo_t),
    .err_misalign(err_misalign_t), .err_timeout(err_timeout_t), .dbg_state(dbg_state_t)
  );

  int total = 0;
  int bad = 0;

  // ---------------- reference model ----------------
  function automatic int lane_of(input logic [31:0] addr);
    return int'(addr % 4);
  endfunction

  function automatic logic [31:0] model_wb_wdata(input logic [2:0] op, input logic [31:0] addr,
                                                 input logic [31:0] wdata, input logic [31:0] rdata);
    int unsigned b;
    b = (rdata / (32'd1 << (8 * lane_of(addr)))) % 256;
    if (op == 3'd1) return rdata;
    if (op == 3'd3) return (b >= 128) ? (32'hFFFF_FFFF - 255 + b) : b;
    if (op == 3'd4) return b;
    return wdata;
  endfunction

  function automatic logic [3:0] model_sel(input logic [2:0] op, input logic [31:0] addr);
    if (op == 3'd1 || op == 3'd2) return 4'hF;
    return 4'(2 ** lane_of(addr));
  endfunction

  function automatic logic [31:0] model_bwdata(input logic [2:0] op, input logic [31:0] sdata);
    if (op == 3'd5) return (sdata % 256) * 32'h0101_0101;
    return sdata;
  endfunction

  logic [31:0] exp_q[$];

  // ---------------- driver ----------------
  int          r_stall, r_busy, r_bubble_bad, r_t;
  logic        r_saw_req, r_hung, r_req_after;
  logic [31:0] r_addr, r_bwdata;
  logic [3:0]  r_sel;
  logic        r_we;
  logic [4:0]  r_wd;
  logic        r_wreg, r_whilo, r_err_mis, r_err_to;
  logic [31:0] r_wdata, r_hi, r_lo;

  task automatic set_idle();
    mem_op = 3'd0; mem_wd = '0; mem_wreg = 1'b0; mem_wdata = '0;
    mem_whilo = 1'b0; mem_hi = '0; mem_lo = '0; mem_addr = '0; mem_sdata = '0;
  endtask

  // Call at posedge+1. Presents one instruction, answers the bus after
  // ack_after non-acked request cycles, and captures the WB result at the
  // edge where the instruction leaves the stage.
  task automatic run_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                        input logic whilo, input logic [31:0] hi, input logic [31:0] lo,
                        input int ack_after, input logic [31:0] rdata);
    int guard;
    r_stall = 0; r_busy = 0; r_saw_req = 1'b0; r_bubble_bad = 0; r_hung = 1'b0; guard = 0;
    mem_op = op; mem_addr = addr; mem_sdata = sdata; mem_wd = wd; mem_wreg = wreg;
    mem_wdata = wdata; mem_whilo = whilo; mem_hi = hi; mem_lo = lo; bus_ack = 1'b0;
    while (1) begin
      if (bus_req) begin
        r_busy++;
        if (!r_saw_req) begin
          r_saw_req = 1'b1; r_addr = bus_addr; r_sel = bus_sel; r_we = bus_we; r_bwdata = bus_wdata;
        end
        if (r_busy == ack_after + 1) begin bus_ack = 1'b1; bus_rdata = rdata; end
      end
      #1;
      if (!stallreq) break;
      r_stall++;
      guard++;
      if (guard > 64) begin r_hung = 1'b1; break; end
      @(posedge clk); #1;
      bus_ack = 1'b0;
      if (wb_wreg) r_bubble_bad++;
    end
    @(posedge clk); #1;
    bus_ack = 1'b0;
    r_wd = wb_wd; r_wreg = wb_wreg; r_wdata = wb_wdata; r_whilo = wb_whilo;
    r_hi = wb_hi; r_lo = wb_lo; r_err_mis = err_misalign; r_err_to = err_timeout;
    r_req_after = bus_req; r_t = cyc_n;
    set_idle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus_req, bus_we, bus_addr, bus_sel, bus_wdata} !== '0) begin
      bad++; $display("FAIL reset_bus: got req=%0b we=%0b addr=%h sel=%h wdata=%h want all 0",
                      bus_req, bus_we, bus_addr, bus_sel, bus_wdata);
    end
    total++;
    if ({wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo, err_misalign, err_timeout} !== '0) begin
      bad++; $display("FAIL reset_wb: got wd=%0d wreg=%0b wdata=%h whilo=%0b hi=%h lo=%h want all 0",
                      wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo);
    end
    total++;
    if (dbg_state !== 1'b0 || stallreq !== 1'b0) begin
      bad++; $display("FAIL reset_state: got state=%0b stall=%0b want 0 0", dbg_state, stallreq);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_passthrough();
    run_op(3'd0, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234, 1'b1, 32'hA, 32'hB, 0, 32'h0);
    total++;
    if ({r_wd, r_wreg, r_wdata, r_whilo, r_hi, r_lo} !== {5'd5, 1'b1, 32'h1234, 1'b1, 32'hA, 32'hB}) begin
      bad++; $display("FAIL passthrough: got wd=%0d wreg=%0b wdata=%h whilo=%0b hi=%h lo=%h want 5 1 1234 1 a b",
                      r_wd, r_wreg, r_wdata, r_whilo, r_hi, r_lo);
    end
    total++;
    if (r_stall !== 0 || r_saw_req !== 1'b0) begin
      bad++; $display("FAIL passthrough_bus: got stall=%0d req=%0b want 0 0", r_stall, r_saw_req);
    end
  endtask

  task automatic test_lw();
    run_op(3'd1, 32'h100, 32'h0, 5'd9, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 3, 32'hDEADBEEF);
    total++;
    if ({r_addr, r_sel, r_we} !== {32'h100, 4'hF, 1'b0}) begin
      bad++; $display("FAIL lw_bus: got addr=%h sel=%h we=%0b want 100 f 0", r_addr, r_sel, r_we);
    end
    total++;
    if (r_stall !== 4 || r_hung !== 1'b0) begin
      bad++; $display("FAIL lw_stall: got %0d cycles hung=%0b want 4", r_stall, r_hung);
    end
    total++;
    if (r_wdata !== 32'hDEADBEEF || r_wreg !== 1'b1 || r_wd !== 5'd9) begin
      bad++; $display("FAIL lw_result: got wdata=%h wreg=%0b wd=%0d want deadbeef 1 9", r_wdata, r_wreg, r_wd);
    end
    total++;
    if (r_bubble_bad !== 0 || r_req_after !== 1'b0) begin
      bad++; $display("FAIL lw_bubble: got bubbles_bad=%0d req_after=%0b want 0 0", r_bubble_bad, r_req_after);
    end
  endtask

  task automatic test_lb_lbu();
    run_op(3'd3, 32'h203, 32'h0, 5'd3, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1, 32'h80123456);
    total++;
    if (r_sel !== 4'b1000 || r_wdata !== 32'hFFFFFF80) begin
      bad++; $display("FAIL lb: got sel=%b wdata=%h want 1000 ffffff80", r_sel, r_wdata);
    end
    run_op(3'd4, 32'h203, 32'h0, 5'd3, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 0, 32'h80123456);
    total++;
    if (r_sel !== 4'b1000 || r_wdata !== 32'h00000080) begin
      bad++; $display("FAIL lbu: got sel=%b wdata=%h want 1000 00000080", r_sel, r_wdata);
    end
  endtask

  task automatic test_sb();
    run_op(3'd5, 32'h301, 32'hAABBCC55, 5'd0, 1'b0, 32'h77, 1'b0, 32'h0, 32'h0, 2, 32'h0);
    total++;
    if ({r_we, r_sel, r_bwdata, r_addr} !== {1'b1, 4'b0010, 32'h55555555, 32'h300}) begin
      bad++; $display("FAIL sb_bus: got we=%0b sel=%b wdata=%h addr=%h want 1 0010 55555555 300",
                      r_we, r_sel, r_bwdata, r_addr);
    end
    total++;
    if (r_wreg !== 1'b0) begin
      bad++; $display("FAIL sb_wreg: got %0b want 0", r_wreg);
    end
  endtask

  task automatic test_misalign();
    run_op(3'd1, 32'h102, 32'h0, 5'd4, 1'b1, 32'h0, 1'b1, 32'h0, 32'h0, 0, 32'h0);
    total++;
    if ({r_saw_req, r_stall[0], r_wreg, r_whilo, r_err_mis} !== {1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      bad++; $display("FAIL misalign: got req=%0b stall=%0d wreg=%0b whilo=%0b err=%0b want 0 0 0 1 1",
                      r_saw_req, r_stall, r_wreg, r_whilo, r_err_mis);
    end
    @(posedge clk); #1;
    total++;
    if (err_misalign !== 1'b0) begin
      bad++; $display("FAIL misalign_pulse: got %0b want 0 on second cycle", err_misalign);
    end
  endtask

  task automatic test_back_to_back();
    int t1;
    run_op(3'd1, 32'h40, 32'h0, 5'd1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 0, 32'h11111111);
    t1 = r_t;
    run_op(3'd1, 32'h44, 32'h0, 5'd2, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 0, 32'h22222222);
    total++;
    if (r_t - t1 !== 2 || r_wdata !== 32'h22222222) begin
      bad++; $display("FAIL back_to_back: got gap=%0d wdata=%h want 2 22222222", r_t - t1, r_wdata);
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] addr, sdata, wdata, hi, lo, rdata, exp_w;
    logic [4:0]  wd;
    logic        wreg, whilo, is_mem, mis;
    int          dly;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr = addr - (addr % 4);
      sdata = $urandom; wdata = $urandom; hi = $urandom; lo = $urandom; rdata = $urandom;
      wd = 5'($urandom_range(0, 31)); wreg = 1'($urandom_range(0, 1)); whilo = 1'($urandom_range(0, 1));
      dly = $urandom_range(0, 5);
      mis = (op == 3'd1 || op == 3'd2) && (addr % 4 != 0);
      is_mem = (op >= 3'd3 && op <= 3'd5) || ((op == 3'd1 || op == 3'd2) && !mis);
      exp_q.push_back(is_mem ? model_wb_wdata(op, addr, wdata, rdata) : wdata);
      run_op(op, addr, sdata, wd, wreg, wdata, whilo, hi, lo, dly, rdata);
      exp_w = exp_q.pop_front();
      total++;
      if (r_stall !== (is_mem ? dly + 1 : 0) || r_saw_req !== is_mem || r_err_mis !== mis) begin
        bad++; $display("FAIL rand_flow[%0d]: op=%0d addr=%h got stall=%0d req=%0b mis=%0b want %0d %0b %0b",
                        i, op, addr, r_stall, r_saw_req, r_err_mis, is_mem ? dly + 1 : 0, is_mem, mis);
      end
      total++;
      if (r_wreg !== (mis ? (op == 3'd2 && wreg) : wreg) || r_whilo !== whilo) begin
        bad++; $display("FAIL rand_wen[%0d]: op=%0d got wreg=%0b whilo=%0b want %0b %0b",
                        i, op, r_wreg, r_whilo, mis ? (op == 3'd2 && wreg) : wreg, whilo);
      end
      if (!mis) begin
        total++;
        if (r_wdata !== exp_w || r_wd !== wd || r_hi !== hi || r_lo !== lo) begin
          bad++; $display("FAIL rand_wb[%0d]: op=%0d got wdata=%h wd=%0d want %h %0d", i, op, r_wdata, r_wd, exp_w, wd);
        end
      end
      if (is_mem) begin
        total++;
        if (r_addr !== addr - (addr % 4) || r_sel !== model_sel(op, addr) ||
            r_we !== (op == 3'd2 || op == 3'd5) || (r_we && r_bwdata !== model_bwdata(op, sdata))) begin
          bad++; $display("FAIL rand_bus[%0d]: op=%0d got addr=%h sel=%b we=%0b wdata=%h want %h %b",
                          i, op, r_addr, r_sel, r_we, r_bwdata, addr - (addr % 4), model_sel(op, addr));
        end
      end
    end
  endtask

  task automatic test_timeout();
    int busy, stall, early, guard;
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0; @(posedge clk); #1;
    busy = 0; stall = 0; early = 0; guard = 0;
    mem_op = 3'd1; mem_addr = 32'h80; mem_wreg = 1'b1; mem_wd = 5'd6;
    while (1) begin
      if (bus_req_t) busy++;
      #1;
      if (!stallreq_t) break;
      stall++; guard++;
      if (guard > 64) break;
      @(posedge clk); #1;
      if (err_timeout_t) early++;
    end
    @(posedge clk); #1;
    total++;
    if (busy !== 4 || stall !== 4 || early !== 0) begin
      bad++; $display("FAIL timeout_len: got busy=%0d stall=%0d early=%0d want 4 4 0", busy, stall, early);
    end
    total++;
    if (err_timeout_t !== 1'b1 || bus_req_t !== 1'b0 || wb_wreg_t !== 1'b0) begin
      bad++; $display("FAIL timeout_abort: got err=%0b req=%0b wreg=%0b want 1 0 0", err_timeout_t, bus_req_t, wb_wreg_t);
    end
    set_idle();
    @(posedge clk); #1;
    total++;
    if (err_timeout_t !== 1'b0 || stallreq_t !== 1'b0) begin
      bad++; $display("FAIL timeout_pulse: got err=%0b stall=%0b want 0 0", err_timeout_t, stallreq_t);
    end
  endtask

  task automatic test_reset_mid_busy();
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    mem_op = 3'd1; mem_addr = 32'h500; mem_wreg = 1'b1; mem_wd = 5'd8;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus_req !== 1'b1) begin
      bad++; $display("FAIL midbusy_setup: got req=%0b want 1", bus_req);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if ({bus_req, bus_addr, wb_wreg, wb_wdata, dbg_state} !== '0) begin
      bad++; $display("FAIL midbusy_reset: got req=%0b addr=%h wreg=%0b state=%0b want 0", bus_req, bus_addr, wb_wreg, dbg_state);
    end
    set_idle();
    mem_wreg = 1'b1; mem_wd = 5'd7; mem_wdata = 32'h1111;
    bus_ack = 1'b1; bus_rdata = 32'h0BAD0BAD;
    #1;
    total++;
    if (stallreq !== 1'b0) begin
      bad++; $display("FAIL late_ack_stall: got %0b want 0", stallreq);
    end
    @(posedge clk); #1;
    bus_ack = 1'b0;
    total++;
    if (bus_req !== 1'b0 || wb_wdata !== 32'h1111 || wb_wd !== 5'd7) begin
      bad++; $display("FAIL late_ack_ignored: got req=%0b wdata=%h wd=%0d want 0 1111 7", bus_req, wb_wdata, wb_wd);
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_lw();
    test_lb_lbu();
    test_sb();
    test_misalign();
    test_back_to_back();
    test_random();
    test_timeout();
    test_reset_mid_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
